// File: rtl/dco_ctrl_pkg.sv
// Shared types and constants for the DCO tuning-word controller.
package dco_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_WAKE,
    ST_RUN,
    ST_UPD_L,
    ST_UPD_M,
    ST_UPD_S
  } dco_state_e;

  localparam int L_DIM = 5;
  localparam int M_DIM = 16;
  localparam int S_DIM = 16;
  localparam int L_MAX = 25;
  localparam int M_MAX = 255;

  typedef struct packed {
    logic [L_DIM-1:0] rall;
    logic [L_DIM-1:0] row;
    logic [L_DIM-1:0] col;
  } l_sel_t;

  typedef struct packed {
    logic [M_DIM-1:0] rall;
    logic [M_DIM-1:0] row;
    logic [M_DIM-1:0] col;
  } ms_sel_t;

  // 8-bit code increment that sticks at the top code.
  function automatic logic [7:0] sat_inc8(input logic [7:0] code);
    return (code == 8'(M_MAX)) ? code : code + 8'd1;
  endfunction

endpackage

// File: rtl/cap_bank_enc.sv
// Thermometer row/column encoder for one DIM x DIM capacitor bank.
// Code N deselects N units: N/DIM full rows plus N%DIM cells of the next row.
module cap_bank_enc #(
  parameter int DIM = 16,
  parameter int CW  = 8
) (
  input  logic [CW-1:0]  code_i,
  output logic [DIM-1:0] rall_o,
  output logic [DIM-1:0] row_o,
  output logic [DIM-1:0] col_o
);

  int q;
  int r;

  // row_o goes all-zero naturally when q reaches DIM.
  always_comb begin
    q = int'(code_i) / DIM;
    r = int'(code_i) % DIM;
    for (int i = 0; i < DIM; i++) begin
      rall_o[i] = (i < q);
      row_o[i]  = (i == q);
      col_o[i]  = (i < r);
    end
  end

endmodule

// File: rtl/dco_ctrl_enc.sv
// DCO controller: power sequencing, tuning-word capture and one-bank-per-cycle apply.
// Optional small-bank dither accumulator enabled by defining DCO_DITHER_EN.
module dco_ctrl_enc
  import dco_ctrl_pkg::*;
#(
  parameter int WAKE_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  // otw_valid_i/otw_ready_o: a word transfers on a rising edge where both are 1;
  // ready is only offered in RUN with en_i high, so a dropped enable never takes a word.
  input  logic        otw_valid_i,
  output logic        otw_ready_o,
  input  logic [4:0]  otw_l_i,
  input  logic [7:0]  otw_m_i,
  input  logic [7:0]  otw_s_i,
  input  logic [1:0]  gain_in_i,
`ifdef DCO_DITHER_EN
  input  logic [3:0]  otw_frac_i,
`endif
  output logic        pd_o,
  output logic [1:0]  osc_gain_o,
  output logic [4:0]  c_l_rall_o,
  output logic [4:0]  c_l_row_o,
  output logic [4:0]  c_l_col_o,
  output logic [15:0] c_m_rall_o,
  output logic [15:0] c_m_row_o,
  output logic [15:0] c_m_col_o,
  output logic [15:0] c_s_rall_o,
  output logic [15:0] c_s_row_o,
  output logic [15:0] c_s_col_o,
  output logic        upd_done_o,
  output logic        err_o,
  output dco_state_e  state_o
);

  localparam int CW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAKE_CYC - 1);

  dco_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    l_cap_q, l_cap_d;
  logic [7:0]    m_cap_q, m_cap_d, s_cap_q, s_cap_d, s_code;
  logic [1:0]    gain_cap_q, gain_cap_d, gain_q, gain_d;
  l_sel_t        l_q, l_d, l_enc;
  ms_sel_t       m_q, m_d, m_enc, s_q, s_d, s_enc;
  logic          upd_done_q, upd_done_d;

`ifdef DCO_DITHER_EN
  logic [3:0] acc_q, acc_d;
  logic [4:0] acc_sum;
  logic       dith_carry;

  // Carry out of the fractional accumulator bumps the small code for one cycle.
  assign acc_sum    = {1'b0, acc_q} + {1'b0, otw_frac_i};
  assign dith_carry = (state_q == ST_RUN) && en_i && acc_sum[4];
  assign acc_d      = ((state_q == ST_RUN) && en_i) ? acc_sum[3:0] : acc_q;
  assign s_code     = dith_carry ? sat_inc8(s_cap_q) : s_cap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end
`else
  assign s_code = s_cap_q;
`endif

  cap_bank_enc #(.DIM(L_DIM), .CW(5)) u_enc_l (
    .code_i(l_cap_q), .rall_o(l_enc.rall), .row_o(l_enc.row), .col_o(l_enc.col));
  cap_bank_enc #(.DIM(M_DIM), .CW(8)) u_enc_m (
    .code_i(m_cap_q), .rall_o(m_enc.rall), .row_o(m_enc.row), .col_o(m_enc.col));
  cap_bank_enc #(.DIM(S_DIM), .CW(8)) u_enc_s (
    .code_i(s_code), .rall_o(s_enc.rall), .row_o(s_enc.row), .col_o(s_enc.col));

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    l_cap_d    = l_cap_q;
    m_cap_d    = m_cap_q;
    s_cap_d    = s_cap_q;
    gain_cap_d = gain_cap_q;
    gain_d     = gain_q;
    l_d        = l_q;
    m_d        = m_q;
    s_d        = s_q;
    upd_done_d = 1'b0;
    // Dropping enable freezes every bank register; pending bank writes are lost.
    if (!en_i) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:  state_d = ST_WAKE;
        ST_WAKE: begin
          if (cnt_q == CNT_LAST) state_d = ST_RUN;
          else                   cnt_d   = cnt_q + CW'(1);
        end
        ST_RUN: begin
`ifdef DCO_DITHER_EN
          s_d = s_enc;
`endif
          if (otw_valid_i) begin
            l_cap_d    = (otw_l_i > 5'(L_MAX)) ? 5'(L_MAX) : otw_l_i;
            m_cap_d    = otw_m_i;
            s_cap_d    = otw_s_i;
            gain_cap_d = gain_in_i;
            state_d    = ST_UPD_L;
          end
        end
        ST_UPD_L: begin
          l_d     = l_enc;
          gain_d  = gain_cap_q;
          state_d = ST_UPD_M;
        end
        ST_UPD_M: begin
          m_d     = m_enc;
          state_d = ST_UPD_S;
        end
        ST_UPD_S: begin
          s_d        = s_enc;
          upd_done_d = 1'b1;
          state_d    = ST_RUN;
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_OFF;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      l_cap_q    <= '0;
      m_cap_q    <= '0;
      s_cap_q    <= '0;
      gain_cap_q <= '0;
      gain_q     <= '0;
      l_q        <= '0;
      m_q        <= '0;
      s_q        <= '0;
      upd_done_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      l_cap_q    <= l_cap_d;
      m_cap_q    <= m_cap_d;
      s_cap_q    <= s_cap_d;
      gain_cap_q <= gain_cap_d;
      gain_q     <= gain_d;
      l_q        <= l_d;
      m_q        <= m_d;
      s_q        <= s_d;
      upd_done_q <= upd_done_d;
    end
  end

  assign pd_o        = (state_q == ST_OFF);
  assign otw_ready_o = (state_q == ST_RUN) && en_i;
  assign err_o       = otw_ready_o && otw_valid_i && (otw_l_i > 5'(L_MAX));
  assign upd_done_o  = upd_done_q;
  assign osc_gain_o  = gain_q;
  assign state_o     = state_q;
  assign c_l_rall_o  = l_q.rall;
  assign c_l_row_o   = l_q.row;
  assign c_l_col_o   = l_q.col;
  assign c_m_rall_o  = m_q.rall;
  assign c_m_row_o   = m_q.row;
  assign c_m_col_o   = m_q.col;
  assign c_s_rall_o  = s_q.rall;
  assign c_s_row_o   = s_q.row;
  assign c_s_col_o   = s_q.col;

endmodule

// File: tb/tb_dco_ctrl_enc.sv
// Self-checking bench for dco_ctrl_enc (default build, dither disabled).
module tb_dco_ctrl_enc;
  import dco_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, en, valid, ready, pd, upd_done, err;
  logic [4:0]  otw_l;
  logic [7:0]  otw_m, otw_s;
  logic [1:0]  gain_in, osc_gain;
  logic [4:0]  l_rall, l_row, l_col;
  logic [15:0] m_rall, m_row, m_col, s_rall, s_row, s_col;
  dco_state_e  st;

  int n_cmp = 0;
  int n_bad = 0;
  logic [22:0] exp_q[$];
  int cur_l = 0, cur_m = 0, cur_s = 0, cur_g = 0;

  typedef struct {
    logic [15:0] rall;
    logic [15:0] row;
    logic [15:0] col;
  } sel_t;

  typedef struct {
    int l; int m; int s; int g; logic er;
    logic [4:0]  lr, lw, lc;
    logic [15:0] mr, mw, mc, sr, sw, sc;
  } vec_t;

  vec_t vt[5];

  dco_ctrl_enc #(.WAKE_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .otw_valid_i(valid), .otw_ready_o(ready),
    .otw_l_i(otw_l), .otw_m_i(otw_m), .otw_s_i(otw_s), .gain_in_i(gain_in),
    .pd_o(pd), .osc_gain_o(osc_gain),
    .c_l_rall_o(l_rall), .c_l_row_o(l_row), .c_l_col_o(l_col),
    .c_m_rall_o(m_rall), .c_m_row_o(m_row), .c_m_col_o(m_col),
    .c_s_rall_o(s_rall), .c_s_row_o(s_row), .c_s_col_o(s_col),
    .upd_done_o(upd_done), .err_o(err), .state_o(st));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference encoding from the counting rule: q full rows, r extra cells.
  function automatic sel_t model_enc(input int n, input int d);
    sel_t e;
    int q, r;
    q = n / d;
    r = n % d;
    e.rall = 16'((1 << q) - 1);
    e.row  = (q < d) ? 16'(1 << q) : 16'd0;
    e.col  = 16'((1 << r) - 1);
    return e;
  endfunction

  function automatic int count_units(input logic [15:0] ra, input logic [15:0] rw,
                                     input logic [15:0] cl, input int d);
    int c = 0;
    for (int i = 0; i < d; i++)
      for (int j = 0; j < d; j++)
        if (ra[i] | (rw[i] & cl[j])) c++;
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pd"}, pd, 1);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_gain"}, osc_gain, 0);
    chk({tag, "_l"}, {l_rall, l_row, l_col}, 0);
    chk({tag, "_m_rall"}, m_rall, 0);
    chk({tag, "_m_row"}, m_row, 0);
    chk({tag, "_m_col"}, m_col, 0);
    chk({tag, "_s_rall"}, s_rall, 0);
    chk({tag, "_s_row"}, s_row, 0);
    chk({tag, "_s_col"}, s_col, 0);
    chk({tag, "_upd_done"}, upd_done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_state"}, 32'(st), 32'(ST_OFF));
  endtask

  task automatic chk_banks(input string tag);
    sel_t el, em, es;
    el = model_enc(cur_l, 5);
    em = model_enc(cur_m, 16);
    es = model_enc(cur_s, 16);
    chk({tag, "_l_rall"}, l_rall, el.rall);
    chk({tag, "_l_row"}, l_row, el.row);
    chk({tag, "_l_col"}, l_col, el.col);
    chk({tag, "_m_rall"}, m_rall, em.rall);
    chk({tag, "_m_row"}, m_row, em.row);
    chk({tag, "_m_col"}, m_col, em.col);
    chk({tag, "_s_rall"}, s_rall, es.rall);
    chk({tag, "_s_row"}, s_row, es.row);
    chk({tag, "_s_col"}, s_col, es.col);
    chk({tag, "_gain"}, osc_gain, cur_g);
  endtask

  // Called at a negedge right after en was raised from OFF.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
      if (n == 1) chk({tag, "_pd_fall"}, pd, 0);
    end
    chk({tag, "_wake_len"}, n, 17);
  endtask

  // Called at a negedge in RUN; returns at a negedge in RUN after upd_done.
  task automatic send_word(input int l, input int m, input int s, input int g, input bit exp_err);
    int lat;
    logic [22:0] w;
    otw_l = 5'(l); otw_m = 8'(m); otw_s = 8'(s); gain_in = 2'(g);
    valid = 1'b1;
    #1;
    chk("hs_ready", ready, 1);
    chk("hs_err", err, exp_err);
    exp_q.push_back({5'((l > 25) ? 25 : l), 8'(m), 8'(s), 2'(g)});
    step();
    valid = 1'b0;
    lat = 1;
    while (!upd_done && lat < 8) begin
      chk("upd_ready_low", ready, 0);
      step();
      lat++;
    end
    chk("upd_latency", lat, 4);
    if (upd_done && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      cur_l = int'(w[22:18]);
      cur_m = int'(w[17:10]);
      cur_s = int'(w[9:2]);
      cur_g = int'(w[1:0]);
      chk_banks("word");
    end
    step();
    chk("upd_done_pulse", upd_done, 0);
  endtask

  initial begin
    vt[0] = '{l:7,  m:83,  s:255, g:1, er:0, lr:5'h01, lw:5'h02, lc:5'h03,
              mr:16'h001F, mw:16'h0020, mc:16'h0007, sr:16'h7FFF, sw:16'h8000, sc:16'h7FFF};
    vt[1] = '{l:30, m:0,   s:0,   g:1, er:1, lr:5'h1F, lw:5'h00, lc:5'h00,
              mr:16'h0000, mw:16'h0001, mc:16'h0000, sr:16'h0000, sw:16'h0001, sc:16'h0000};
    vt[2] = '{l:25, m:255, s:0,   g:3, er:0, lr:5'h1F, lw:5'h00, lc:5'h00,
              mr:16'h7FFF, mw:16'h8000, mc:16'h7FFF, sr:16'h0000, sw:16'h0001, sc:16'h0000};
    vt[3] = '{l:0,  m:0,   s:16,  g:2, er:0, lr:5'h00, lw:5'h01, lc:5'h00,
              mr:16'h0000, mw:16'h0001, mc:16'h0000, sr:16'h0001, sw:16'h0002, sc:16'h0000};
    vt[4] = '{l:31, m:17,  s:1,   g:0, er:1, lr:5'h1F, lw:5'h00, lc:5'h00,
              mr:16'h0001, mw:16'h0002, mc:16'h0001, sr:16'h0000, sw:16'h0001, sc:16'h0001};

    rst_n = 1'b0; en = 1'b0; valid = 1'b0;
    otw_l = '0; otw_m = '0; otw_s = '0; gain_in = '0;
    @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    step();
    chk("off_idle_pd", pd, 1);
    en = 1'b1;
    wait_ready("wake0");

    // Fixed vectors with hand-derived selects.
    for (int k = 0; k < 5; k++) begin
      send_word(vt[k].l, vt[k].m, vt[k].s, vt[k].g, vt[k].er);
      chk("vec_l", {l_rall, l_row, l_col}, {vt[k].lr, vt[k].lw, vt[k].lc});
      chk("vec_m", {m_rall, m_row}, {vt[k].mr, vt[k].mw});
      chk("vec_m_col", m_col, vt[k].mc);
      chk("vec_s", {s_rall, s_row}, {vt[k].sr, vt[k].sw});
      chk("vec_s_col", s_col, vt[k].sc);
      chk("vec_gain", osc_gain, vt[k].g);
    end

    // Random words against the model plus the deselected-unit count.
    for (int k = 0; k < 24; k++) begin
      int l, m, s, g;
      l = $urandom_range(0, 31);
      m = $urandom_range(0, 255);
      s = $urandom_range(0, 255);
      g = $urandom_range(0, 3);
      send_word(l, m, s, g, l > 25);
      chk("units_l", count_units({11'd0, l_rall}, {11'd0, l_row}, {11'd0, l_col}, 5), cur_l);
      chk("units_m", count_units(m_rall, m_row, m_col, 16), m);
      chk("units_s", count_units(s_rall, s_row, s_col, 16), s);
    end

    // Enable drops during UPD_M: L already applied, M and S keep old values.
    send_word(9, 60, 200, 1, 0);
    otw_l = 5'd12; otw_m = 8'd40; otw_s = 8'd77; gain_in = 2'd2;
    valid = 1'b1;
    step();
    valid = 1'b0;
    chk("abort_in_upd_l", 32'(st), 32'(ST_UPD_L));
    step();
    chk("abort_in_upd_m", 32'(st), 32'(ST_UPD_M));
    en = 1'b0;
    step();
    chk("abort_pd", pd, 1);
    chk("abort_state", 32'(st), 32'(ST_OFF));
    chk("abort_upd_done", upd_done, 0);
    cur_l = 12;
    cur_g = 2;
    chk_banks("abort");
    en = 1'b1;
    wait_ready("wake1");
    chk_banks("after_wake");

    // Enable low together with valid in RUN: no capture, straight to OFF.
    en = 1'b0;
    otw_l = 5'd30; otw_m = 8'd1; otw_s = 8'd2; gain_in = 2'd3;
    valid = 1'b1;
    #1;
    chk("noen_err", err, 0);
    step();
    valid = 1'b0;
    chk("noen_state", 32'(st), 32'(ST_OFF));
    step();
    chk("noen_upd_done", upd_done, 0);
    chk_banks("noen");
    en = 1'b1;
    wait_ready("wake2");
    chk_banks("noen_after");

    // Asynchronous reset in the middle of UPD_L.
    otw_l = 5'd20; otw_m = 8'd99; otw_s = 8'd150; gain_in = 2'd3;
    valid = 1'b1;
    @(posedge clk);
    #2;
    valid = 1'b0;
    chk("rst_in_upd_l", 32'(st), 32'(ST_UPD_L));
    rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    @(negedge clk);
    chk_reset("held_rst");
    rst_n = 1'b1;
    cur_l = 0; cur_m = 0; cur_s = 0; cur_g = 0;
    wait_ready("wake3");
    send_word(3, 130, 45, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
